// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder around one sum1b full adder; optional subtract mode under SERIAL_ADDER_SUB_EN

module sum1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_carry;
  logic [CNT_W-1:0] r_bit_cnt;

  logic [WIDTH-1:0] w_s_sh_nxt;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  sum1b u_sum1b (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_bit_cnt == LAST_BIT);

  // New sum bit enters at the MSB; written as shift/or so WIDTH=1 needs no special case.
  assign w_s_sh_nxt = (r_s_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1, so the inverted operand and a forced carry are loaded up front.
  assign w_b_load     = op ? ~b_in : b_in;
  assign w_carry_load = op ? 1'b1  : ci_in;
`else
  assign w_b_load     = b_in;
  assign w_carry_load = ci_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_bit_cnt == LAST_BIT) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shifting, carry, bit counting; result registers load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
      r_sum     <= '0;
      r_co      <= 1'b0;
    end else if (w_accept) begin
      r_a_sh    <= a_in;
      r_b_sh    <= w_b_load;
      r_carry   <= w_carry_load;
      r_bit_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh    <= r_a_sh >> 1;
      r_b_sh    <= r_b_sh >> 1;
      r_s_sh    <= w_s_sh_nxt;
      r_carry   <= w_co;
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum <= w_s_sh_nxt;
        r_co  <= w_co;
      end
    end
  end

  assign sum = r_sum;
  assign co  = r_co;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH=4 and WIDTH=1)

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       ci4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       co4;
`ifdef SERIAL_ADDER_SUB_EN
  logic       op4;
  logic       op1;
`endif

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ci1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       co1;

  int n_checks;
  int n_fail;

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a_in  (a4),
    .b_in  (b4),
    .ci_in (ci4),
`ifdef SERIAL_ADDER_SUB_EN
    .op    (op4),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .co    (co4)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a_in  (a1),
    .b_in  (b1),
    .ci_in (ci1),
`ifdef SERIAL_ADDER_SUB_EN
    .op    (op1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .co    (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request on the WIDTH=4 instance; done is expected WIDTH clocks after
  // the accepting edge, i.e. on the 5th falling edge after driving start.
  task automatic run_add4(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic ci, input logic [3:0] exp_sum, input logic exp_co);
    int k;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
      if (done4) begin
        k = i;
        break;
      end
    end
    chk({tag, "_latency"}, k, 5);
    chk({tag, "_sum"}, sum4, exp_sum);
    chk({tag, "_co"}, co4, exp_co);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done4, 1'b0);
  endtask

  logic [7:0] tt_s;
  logic [7:0] tt_co;
  int         k1;
  int         n_done;
  int         last_done;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    op4 = 1'b0; op1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_sum", sum4, 4'h0);
    chk("rst_co", co4, 1'b0);
    rst = 1'b0;

    // Addition cases
    run_add4("add_5_3", 4'h5, 4'h3, 1'b0, 4'h8, 1'b0);
    run_add4("add_f_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    run_add4("add_9_6_c", 4'h9, 4'h6, 1'b1, 4'h0, 1'b1);
    run_add4("add_f_f_c", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);

    // WIDTH=1 full-adder truth table, index = {a,b,ci}
    tt_s  = 8'b1001_0110;
    tt_co = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
      k1 = 0;
      for (int j = 1; j <= 6; j++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1) begin
          k1 = j;
          break;
        end
      end
      chk($sformatf("w1_lat_%0d", i), k1, 2);
      chk($sformatf("w1_s_%0d", i), sum1, tt_s[i]);
      chk($sformatf("w1_co_%0d", i), co1, tt_co[i]);
    end

    // start pulsed during RUN is ignored; sum holds previous result (0xF) until DONE
    @(negedge clk);
    start4 = 1'b1; a4 = 4'h2; b4 = 4'h2; ci4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start4 = 1'b1; a4 = 4'h7; b4 = 4'h7;
      end else begin
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      end
      chk($sformatf("ign_busy_%0d", i), busy4, 1'b1);
      chk($sformatf("ign_hold_%0d", i), sum4, 4'hF);
    end
    @(negedge clk);
    chk("ign_done", done4, 1'b1);
    chk("ign_sum", sum4, 4'h4);
    chk("ign_co", co4, 1'b0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    chk("ign_extra_done", n_done, 0);

    // Reset at the second RUN edge aborts the operation
    @(negedge clk);
    start4 = 1'b1; a4 = 4'hA; b4 = 4'h5; ci4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    chk("abort_sum", sum4, 4'h0);
    chk("abort_co", co4, 1'b0);
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_add4("post_abort", 4'h1, 4'h1, 1'b0, 4'h2, 1'b0);

    // start held high: one result every WIDTH+2 = 6 clocks
    @(negedge clk);
    start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; ci4 = 1'b0;
    n_done = 0;
    last_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done4) begin
        n_done++;
        chk($sformatf("hold_gap_%0d", n_done), i - last_done, (n_done == 1) ? 5 : 6);
        chk($sformatf("hold_sum_%0d", n_done), sum4, 4'h2);
        last_done = i;
      end
    end
    chk("hold_count", n_done, 3);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op4 = 1'b1;
    run_add4("sub_5_3", 4'h5, 4'h3, 1'b0, 4'h2, 1'b1);
    run_add4("sub_3_5", 4'h3, 4'h5, 1'b1, 4'hE, 1'b0);
    op4 = 1'b0;
    run_add4("op0_3_5", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
